// File: rtl/seq_mac_pkg.sv
// Shared op codes, FSM state encoding and helpers for the sequential MAC datapath.
package seq_mac_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_ADD = 2'd1,
    OP_MAC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MULT = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // True for the operations that need the shift-add multiplier.
  function automatic logic uses_mult(input op_e op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: load captures operands, each step retires one multiplier bit.
module seq_multiplier #(
  parameter int unsigned p_width = 7
) (
  input  logic                   i_w_clk,
  input  logic                   i_w_reset,
  input  logic                   i_w_load,
  input  logic                   i_w_step,
  input  logic [p_width-1:0]     i_w_a,
  input  logic [p_width-1:0]     i_w_b,
  output logic [2*p_width-1:0]   o_w_product,
  output logic                   o_w_done_c
);

  localparam int unsigned W  = p_width;
  localparam int unsigned PW = 2 * p_width;
  localparam int unsigned CW = $clog2(p_width);

  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;

  // High on the step that retires the last multiplier bit; the product is final after this edge.
  assign o_w_done_c = i_w_step && (cnt == CW'(W - 1));

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      o_w_product <= '0;
    end else if (i_w_load) begin
      mcand       <= PW'(i_w_a);
      mplier      <= i_w_b;
      cnt         <= '0;
      o_w_product <= '0;
    end else if (i_w_step) begin
      if (mplier[0]) begin
        o_w_product <= o_w_product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_mac_unit.sv
// Operand register bank, control FSM, accumulator and gated result output around seq_multiplier.
module seq_mac_unit
  import seq_mac_pkg::*;
#(
  parameter  int unsigned p_data_width = 7,
  parameter  int unsigned p_depth      = 4,
  localparam int unsigned p_addr_width = $clog2(p_depth)
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic                      i_w_write,
  input  logic [p_addr_width-1:0]   i_w_waddr,
  input  logic [p_data_width-1:0]   i_w_data,
  input  logic                      i_w_start,
  input  logic [1:0]                i_w_op,
  input  logic [p_addr_width-1:0]   i_w_sel_a,
  input  logic [p_addr_width-1:0]   i_w_sel_b,
  input  logic                      i_w_display,
  output logic [2*p_data_width-1:0] o_w_out,
  output logic                      o_w_busy,
  output logic                      o_w_done,
  output logic                      o_w_overflow
);

  localparam int unsigned W  = p_data_width;
  localparam int unsigned DW = 2 * p_data_width;
  localparam int unsigned AW = p_addr_width;

  logic [W-1:0]  bank [p_depth];
  state_e        state;
  op_e           op_q;
  logic [AW-1:0] sel_a_q;
  logic [AW-1:0] sel_b_q;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [DW-1:0] acc;
  logic [DW-1:0] result;

  logic [W-1:0]  rd_a_c;
  logic [W-1:0]  rd_b_c;
  logic [DW-1:0] product;
  logic          mult_done_c;
  logic          mult_load_c;
  logic          mult_step_c;
  logic [DW:0]   mac_sum_c;

  assign rd_a_c      = bank[sel_a_q];
  assign rd_b_c      = bank[sel_b_q];
  assign mult_load_c = (state == S_LOAD) && uses_mult(op_q);
  assign mult_step_c = (state == S_MULT);
  // Extra top bit captures the accumulator carry-out for the sticky overflow flag.
  assign mac_sum_c   = {1'b0, acc} + {1'b0, product};
  assign o_w_out     = i_w_display ? result : '0;

  seq_multiplier #(
    .p_width (W)
  ) u_mult (
    .i_w_clk     (i_w_clk),
    .i_w_reset   (i_w_reset),
    .i_w_load    (mult_load_c),
    .i_w_step    (mult_step_c),
    .i_w_a       (rd_a_c),
    .i_w_b       (rd_b_c),
    .o_w_product (product),
    .o_w_done_c  (mult_done_c)
  );

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      for (int i = 0; i < int'(p_depth); i++) begin
        bank[i] <= '0;
      end
      state        <= S_IDLE;
      op_q         <= OP_MUL;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      opa          <= '0;
      opb          <= '0;
      acc          <= '0;
      result       <= '0;
      o_w_busy     <= 1'b0;
      o_w_done     <= 1'b0;
      o_w_overflow <= 1'b0;
    end else begin
      o_w_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_w_write) begin
            bank[i_w_waddr] <= i_w_data;
          end
          if (i_w_start) begin
            op_q     <= op_e'(i_w_op);
            sel_a_q  <= i_w_sel_a;
            sel_b_q  <= i_w_sel_b;
            o_w_busy <= 1'b1;
            state    <= S_LOAD;
          end
        end
        // Bank is read one edge after start so a same-cycle write is observed.
        S_LOAD: begin
          opa   <= rd_a_c;
          opb   <= rd_b_c;
          state <= uses_mult(op_q) ? S_MULT : S_WB;
        end
        S_MULT: begin
          if (mult_done_c) begin
            state <= S_WB;
          end
        end
        S_WB: begin
          case (op_q)
            OP_MUL: result <= product;
            OP_ADD: result <= DW'(opa) + DW'(opb);
            OP_MAC: begin
              acc    <= mac_sum_c[DW-1:0];
              result <= mac_sum_c[DW-1:0];
              if (mac_sum_c[DW]) begin
                o_w_overflow <= 1'b1;
              end
            end
            default: begin
              acc          <= '0;
              result       <= '0;
              o_w_overflow <= 1'b0;
            end
          endcase
          o_w_done <= 1'b1;
          o_w_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_unit.sv
// Self-checking bench for seq_mac_unit: directed cases plus random ops against an arithmetic model.
module tb_seq_mac_unit;

  localparam int unsigned W  = 7;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 14;

  logic          clk;
  logic          rst_n;
  logic          write;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] sel_a;
  logic [AW-1:0] sel_b;
  logic          display;
  logic [DW-1:0] out;
  logic          busy;
  logic          done;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  // Reference state: bank contents, accumulator, last result, sticky overflow.
  int unsigned m_bank [D];
  int unsigned m_acc;
  int unsigned m_res;
  bit          m_ovf;

  seq_mac_unit #(
    .p_data_width (W),
    .p_depth      (D)
  ) dut (
    .i_w_clk      (clk),
    .i_w_reset    (rst_n),
    .i_w_write    (write),
    .i_w_waddr    (waddr),
    .i_w_data     (wdata),
    .i_w_start    (start),
    .i_w_op       (op),
    .i_w_sel_a    (sel_a),
    .i_w_sel_b    (sel_b),
    .i_w_display  (display),
    .o_w_out      (out),
    .o_w_busy     (busy),
    .o_w_done     (done),
    .o_w_overflow (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(D); i++) m_bank[i] = 0;
    m_acc = 0;
    m_res = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_op(input int unsigned o, input int unsigned a, input int unsigned b);
    int unsigned va;
    int unsigned vb;
    int unsigned s;
    va = m_bank[a];
    vb = m_bank[b];
    case (o)
      0: m_res = va * vb;
      1: m_res = va + vb;
      2: begin
        s = m_acc + va * vb;
        if (s >= (32'd1 << DW)) m_ovf = 1'b1;
        m_acc = s % (32'd1 << DW);
        m_res = m_acc;
      end
      default: begin
        m_acc = 0;
        m_res = 0;
        m_ovf = 1'b0;
      end
    endcase
  endtask

  task automatic wr(input int unsigned a, input int unsigned d);
    write = 1'b1;
    waddr = AW'(a);
    wdata = W'(d);
    tick();
    write = 1'b0;
    m_bank[a] = d;
  endtask

  task automatic run_op(input int unsigned o, input int unsigned a, input int unsigned b,
                        input bit disturb, input bit same_wr,
                        input int unsigned wa, input int unsigned wd);
    int n;
    int busy_cycles;
    int exp_lat;
    op    = 2'(o);
    sel_a = AW'(a);
    sel_b = AW'(b);
    start = 1'b1;
    if (same_wr) begin
      write = 1'b1;
      waddr = AW'(wa);
      wdata = W'(wd);
      m_bank[wa] = wd;
    end
    tick();
    start = 1'b0;
    write = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && n < 40) begin
      if (disturb) begin
        write = 1'b1;
        waddr = AW'($urandom);
        wdata = W'($urandom);
        start = 1'b1;
        op    = 2'($urandom);
        sel_a = AW'($urandom);
        sel_b = AW'($urandom);
      end
      tick();
      n++;
      if (busy) busy_cycles++;
    end
    write = 1'b0;
    start = 1'b0;
    exp_lat = (o == 0 || o == 2) ? int'(W) + 2 : 2;
    model_op(o, a, b);
    chk("done_latency", 64'(n), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_cycles), 64'(exp_lat));
    chk("result", out, 64'(m_res));
    chk("overflow", ovf, 64'(m_ovf));
    display = 1'b0;
    #1;
    chk("display_off", out, 0);
    display = 1'b1;
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    write   = 1'b0;
    waddr   = '0;
    wdata   = '0;
    start   = 1'b0;
    op      = '0;
    sel_a   = '0;
    sel_b   = '0;
    display = 1'b1;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_out", out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);

    wr(1, 13);
    wr(2, 9);
    run_op(0, 1, 2, 0, 0, 0, 0);
    chk("mul_13x9", out, 117);

    wr(3, 127);
    run_op(1, 3, 3, 0, 0, 0, 0);
    chk("add_127x2", out, 254);

    run_op(2, 3, 3, 0, 0, 0, 0);
    chk("mac_first", out, 16129);
    run_op(2, 3, 3, 0, 0, 0, 0);
    chk("mac_wrap", out, 15874);
    chk("mac_ovf_set", ovf, 1);
    run_op(2, 1, 2, 0, 0, 0, 0);
    chk("ovf_sticky", ovf, 1);
    run_op(3, 0, 0, 0, 0, 0, 0);
    chk("clr_result", out, 0);
    chk("clr_ovf", ovf, 0);

    run_op(0, 1, 2, 1, 0, 0, 0);
    run_op(0, 1, 2, 0, 0, 0, 0);
    chk("bank_untouched_busy", out, 117);

    run_op(0, 0, 0, 0, 1, 0, 100);
    chk("same_cycle_write", out, 10000);

    repeat (40) begin
      if ($urandom_range(1, 0) == 1) wr($urandom_range(D - 1, 0), $urandom_range(127, 0));
      run_op($urandom_range(3, 0), $urandom_range(D - 1, 0), $urandom_range(D - 1, 0),
             $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
             $urandom_range(D - 1, 0), $urandom_range(127, 0));
    end

    // Force overflow, then abort a MUL with reset part-way through.
    wr(3, 127);
    run_op(2, 3, 3, 0, 0, 0, 0);
    run_op(2, 3, 3, 0, 0, 0, 0);
    op    = 2'd0;
    sel_a = 2'd3;
    sel_b = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_out", out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      chk("post_reset_no_done", done, 0);
    end
    chk("post_reset_out", out, 0);
    chk("post_reset_busy", busy, 0);
    run_op(0, 3, 3, 0, 0, 0, 0);
    chk("bank_cleared", out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
